// File: rtl/digital_lock_pkg.sv
// -----------------------------------------------------------------------------
// digital_lock_pkg
//   Shared definitions for the keypad front end and the lock logic it feeds.
//   - state_t        : debounce FSM state encoding (2 bits)
//   - onehot()       : true when exactly one bit of the argument is set
//   - DEF_* constants: default parameter values for key_press_encoder
// -----------------------------------------------------------------------------
package digital_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam int unsigned DEF_N               = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 500000;

  // Callers zero-extend their vector to 32 bits; widths up to 32 supported.
  function automatic logic onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/button_synchroniser.sv
// -----------------------------------------------------------------------------
// button_synchroniser
//   Two-flop synchroniser for N asynchronous active-low buttons. Both stages
//   reset to all-ones so every button reads as released out of reset.
//   Ports:
//     clock      in  1  system clock, rising edge
//     reset      in  1  asynchronous, active-high
//     i_key_n    in  N  raw active-low buttons
//     o_key_n    out N  synchronised active-low buttons (second stage)
// -----------------------------------------------------------------------------
module button_synchroniser #(
  parameter int unsigned N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] i_key_n,
  output logic [N-1:0] o_key_n
);

  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign o_key_n = r_sync2;

endmodule

// File: rtl/key_press_encoder.sv
// -----------------------------------------------------------------------------
// key_press_encoder
//   Synchronises and debounces N active-low push buttons and emits one
//   single-cycle one-hot key code per accepted press. Presses with more than
//   one button down produce a one-cycle multi_error pulse instead.
//   Optional feature (macro KEY_TIMEOUT_EN): inactivity timer that pulses
//   timeout TIMEOUT_CYCLES cycles after the last key pulse. Without the macro
//   timeout is tied low.
//   Ports:
//     clock        in  1  system clock, rising edge
//     reset        in  1  asynchronous, active-high
//     key_n        in  N  raw active-low buttons
//     key          out N  one-hot accepted key, 1-cycle pulse
//     multi_error  out 1  1-cycle pulse: debounced press had >1 button down
//     held         out 1  level: accepted/rejected press still held
//     timeout      out 1  1-cycle pulse: inactivity after last key
// -----------------------------------------------------------------------------
module key_press_encoder
  import digital_lock_pkg::*;
#(
  parameter int unsigned N               = DEF_N,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] key_n,
  output logic [N-1:0] key,
  output logic         multi_error,
  output logic         held,
  output logic         timeout
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  w_key_n_sync;
  logic [N-1:0]  w_pressed;
  logic          w_stable_done;
  logic          w_emit;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_cand;
  logic [N-1:0]  r_key;
  logic          r_multi;
  logic          r_held;

  button_synchroniser #(.N(N)) u_sync (
    .clock   (clock),
    .reset   (reset),
    .i_key_n (key_n),
    .o_key_n (w_key_n_sync)
  );

  assign w_pressed = ~w_key_n_sync;

  // Debounce window complete with the candidate pattern still present.
  assign w_stable_done = (r_state == ST_DEBOUNCE) && (w_pressed == r_cand) &&
                         (r_cnt == CNT_LAST);
  // A key pulse is registered on this edge; also drives the inactivity timer.
  assign w_emit = w_stable_done && onehot(32'(r_cand));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_key   <= '0;
      r_multi <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_key   <= '0;
      r_multi <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pressed != '0) begin
            r_cand  <= w_pressed;
            r_cnt   <= '0;
            r_state <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (w_pressed != r_cand) begin
            // Glitch: drop the candidate silently.
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (w_stable_done) begin
            if (w_emit) r_key   <= r_cand;
            else        r_multi <= 1'b1;
            r_cnt   <= '0;
            r_held  <= 1'b1;
            r_state <= ST_HELD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_HELD: begin
          // Pattern changes while held are ignored until a full release.
          if (w_pressed == '0) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_pressed != '0) begin
            r_cnt   <= '0;
            r_state <= ST_HELD;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_held  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_held  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign key         = r_key;
  assign multi_error = r_multi;
  assign held        = r_held;

`ifdef KEY_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_timer;
  logic          r_armed;
  logic          r_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer   <= '0;
      r_armed   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // A key pulse on the expiry edge takes priority: re-arm, no timeout.
      if (w_emit) begin
        r_armed <= 1'b1;
        r_timer <= '0;
      end else if (r_armed) begin
        if (r_timer == TMR_LAST) begin
          r_timeout <= 1'b1;
          r_armed   <= 1'b0;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_key_press_encoder.sv
module tb_key_press_encoder;

  localparam int unsigned N  = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned TO = 20;

  localparam int unsigned EV_KEY   = 0;
  localparam int unsigned EV_MULTI = 1;
  localparam int unsigned EV_TMO   = 2;

  typedef struct {
    int unsigned kind;
    logic [3:0]  val;
    int unsigned cyc;
  } ev_t;

  logic         clock;
  logic         reset;
  logic [N-1:0] key_n;
  logic [N-1:0] key;
  logic         multi_error;
  logic         held;
  logic         timeout;

  int unsigned  n_tests;
  int unsigned  n_fail;
  int unsigned  cyc;
  ev_t          sb[$];

  key_press_encoder #(
    .N               (N),
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_n       (key_n),
    .key         (key),
    .multi_error (multi_error),
    .held        (held),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int unsigned kind, input logic [3:0] val, input int unsigned at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic take_ev(input int unsigned kind, input logic [3:0] val);
    ev_t e;
    if (sb.size() == 0) begin
      check_eq("unexpected_event", kind + 32'd100, 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      check_eq("ev_kind", kind, e.kind);
      check_eq("ev_cycle", cyc, e.cyc);
      check_eq("ev_val", {28'd0, val}, {28'd0, e.val});
    end
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (key != '0)  take_ev(EV_KEY, key);
    if (multi_error) take_ev(EV_MULTI, 4'b0000);
    if (timeout)     take_ev(EV_TMO, 4'b0000);
  end

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_timeout(input int unsigned at);
`ifdef KEY_TIMEOUT_EN
    push_ev(EV_TMO, 4'b0000, at);
`else
    if (at == 0) $display("note: timeout not expected at %0d", at);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    logic hmax;
    n_tests = 0;
    n_fail  = 0;
    key_n   = '1;
    reset   = 1'b1;
    step(3);
    check_eq("rst_key", key, 0);
    check_eq("rst_multi", multi_error, 0);
    check_eq("rst_held", held, 0);
    check_eq("rst_timeout", timeout, 0);
    reset = 1'b0;
    step(2);

    // 1: single clean press of button 0
    c = cyc;
    key_n = 4'b1110;
    push_ev(EV_KEY, 4'b0001, c + 7);
    push_timeout(c + 27);
    step(6);
    check_eq("t1_held_before", held, 0);
    step(1);
    check_eq("t1_held_on_key", held, 1);
    step(13);
    key_n = 4'b1111;
    step(6);
    check_eq("t1_held_release", held, 1);
    step(1);
    check_eq("t1_held_cleared", held, 0);
    step(30);

    // 2: short glitch is rejected
    key_n = 4'b1101;
    step(2);
    key_n = 4'b1111;
    hmax = 1'b0;
    repeat (12) begin
      step(1);
      hmax = hmax | held;
    end
    check_eq("t2_held_never", hmax, 0);

    // 3: two buttons at once -> multi_error
    c = cyc;
    key_n = 4'b1100;
    push_ev(EV_MULTI, 4'b0000, c + 7);
    step(8);
    check_eq("t3_held", held, 1);
    step(2);
    key_n = 4'b1111;
    step(6);
    check_eq("t3_held_release", held, 1);
    step(1);
    check_eq("t3_held_cleared", held, 0);
    step(5);

    // 4: release bounce while held gives only one key
    c = cyc;
    key_n = 4'b0111;
    push_ev(EV_KEY, 4'b1000, c + 7);
    push_timeout(c + 27);
    step(10);
    key_n = 4'b1111;
    step(2);
    key_n = 4'b0111;
    step(4);
    check_eq("t4_held_bounce", held, 1);
    step(4);
    key_n = 4'b1111;
    step(7);
    check_eq("t4_held_cleared", held, 0);
    step(30);

    // 5: timeout after a key, exactly once
    c = cyc;
    key_n = 4'b1101;
    push_ev(EV_KEY, 4'b0010, c + 7);
    push_timeout(c + 27);
    step(8);
    key_n = 4'b1111;
    step(40);
    check_eq("t5_timeout_low", timeout, 0);

    // 6: reset during debounce, button kept down
    key_n = 4'b1110;
    step(4);
    reset = 1'b1;
    step(1);
    check_eq("t6_rst_key", key, 0);
    check_eq("t6_rst_held", held, 0);
    check_eq("t6_rst_multi", multi_error, 0);
    check_eq("t6_rst_timeout", timeout, 0);
    step(2);
    reset = 1'b0;
    c = cyc;
    push_ev(EV_KEY, 4'b0001, c + 7);
    push_timeout(c + 27);
    step(10);
    key_n = 4'b1111;
    step(30);

    check_eq("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
